// File: rtl/rf_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_if
// Description : Register-file write-port bundle: WB stage, long-latency unit,
//               pending scoreboard and registered write outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_wb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    logic            pipe_we;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_data;
    logic            pipe_stall;
    logic            mc_issue;
    logic [4:0]      mc_issue_rd;
    logic            mc_valid;
    logic            mc_ready;
    logic [4:0]      mc_rd;
    logic [XLEN-1:0] mc_data;
    logic [NREG-1:0] pending;
    logic            rf_we;
    logic [4:0]      rf_addr;
    logic [XLEN-1:0] rf_data;

    modport master (
        output pipe_we, pipe_rd, pipe_data, mc_issue, mc_issue_rd,
               mc_valid, mc_rd, mc_data,
        input  pipe_stall, mc_ready, pending, rf_we, rf_addr, rf_data
    );

    modport slave (
        input  pipe_we, pipe_rd, pipe_data, mc_issue, mc_issue_rd,
               mc_valid, mc_rd, mc_data,
        output pipe_stall, mc_ready, pending, rf_we, rf_addr, rf_data
    );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Shares the register-file write port between the WB stage and
//               a buffered long-latency unit with starvation-forced priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int NREG         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    rf_wb_if.slave    bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);

    logic [XLEN-1:0]    r_fifo_data [FIFO_DEPTH];
    logic [4:0]         r_fifo_rd   [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_STV_W-1:0] r_starve;
    logic [NREG-1:0]    r_pending;
    logic               r_rf_we;
    logic [4:0]         r_rf_addr;
    logic [XLEN-1:0]    r_rf_data;

    logic               w_empty;
    logic               w_full;
    logic               w_stall;
    logic               w_push;
    logic               w_pipe_gnt;
    logic               w_fifo_gnt;
    logic [4:0]         w_head_rd;
    logic [XLEN-1:0]    w_head_data;
    logic [NREG-1:0]    w_pending_nxt;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_stall     = (r_starve == c_STV_W'(STARVE_LIMIT));
    // No pop-through: a full buffer refuses data even while draining.
    assign w_push      = bus.mc_valid && !w_full;
    assign w_head_rd   = r_fifo_rd[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    always_comb begin
        w_pipe_gnt = 1'b0;
        w_fifo_gnt = 1'b0;
        if (w_stall) begin
            w_fifo_gnt = !w_empty;
        end else if (bus.pipe_we && (bus.pipe_rd != 5'd0)) begin
            w_pipe_gnt = 1'b1;
        end else if (!w_empty) begin
            w_fifo_gnt = 1'b1;
        end
    end

    // Set beats clear when a new issue targets the register being retired.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_fifo_gnt && (w_head_rd != 5'd0)) begin
            w_pending_nxt[w_head_rd] = 1'b0;
        end
        if (bus.mc_issue && (bus.mc_issue_rd != 5'd0)) begin
            w_pending_nxt[bus.mc_issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= bus.mc_data;
            r_fifo_rd[r_wr_ptr]   <= bus.mc_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_pending <= '0;
            r_rf_we   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_fifo_gnt) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_fifo_gnt})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_fifo_gnt || w_empty) begin
                r_starve <= '0;
            end else if (!w_stall) begin
                r_starve <= r_starve + c_STV_W'(1);
            end

            r_pending <= w_pending_nxt;

            if (w_pipe_gnt) begin
                r_rf_we   <= 1'b1;
                r_rf_addr <= bus.pipe_rd;
                r_rf_data <= bus.pipe_data;
            end else if (w_fifo_gnt && (w_head_rd != 5'd0)) begin
                r_rf_we   <= 1'b1;
                r_rf_addr <= w_head_rd;
                r_rf_data <= w_head_data;
            end else begin
                r_rf_we   <= 1'b0;
            end
        end
    end

    assign bus.pipe_stall = w_stall;
    assign bus.mc_ready   = !w_full;
    assign bus.pending    = r_pending;
    assign bus.rf_we      = r_rf_we;
    assign bus.rf_addr    = r_rf_addr;
    assign bus.rf_data    = r_rf_data;
endmodule
`default_nettype wire
